// File: rtl/hash_core_scheduler.sv
// Round-robin nonce dispatcher and score collector shared by NUM_CORES hash cores.
// Tracks the lowest score seen in a run together with the nonce that produced it.
module hash_core_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int SCORE_W   = 11
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic [NONCE_W-1:0]           nonce_base_i,
    input  logic [NUM_CORES-1:0]         core_ready_i,
    output logic [NUM_CORES-1:0]         core_start_o,
    output logic [NONCE_W-1:0]           core_nonce_o,
    input  logic [NUM_CORES-1:0]         core_done_i,
    input  logic [NUM_CORES*SCORE_W-1:0] core_score_i,
    output logic [NUM_CORES-1:0]         core_ack_o,
    output logic                         busy_o,
    output logic                         best_valid_o,
    output logic [SCORE_W-1:0]           best_score_o,
    output logic [NONCE_W-1:0]           best_nonce_o,
    output logic                         best_update_o,
    output logic [NONCE_W-1:0]           issued_count_o
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] outst_q, outst_d;
    logic [PTR_W-1:0]     iss_ptr_q, iss_ptr_d, col_ptr_q, col_ptr_d;
    logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
    logic [NONCE_W-1:0]   issued_q, issued_d;
    logic [NONCE_W-1:0]   nonce_tbl_q [NUM_CORES];
    logic                 best_valid_q, best_valid_d;
    logic [SCORE_W-1:0]   best_score_q, best_score_d;
    logic [NONCE_W-1:0]   best_nonce_q, best_nonce_d;
    logic                 best_update_q, best_update_d;

    logic [NUM_CORES-1:0] grant_req, ack_req;
    logic [PTR_W:0]       grant_pick, ack_pick;
    logic                 grant_vld, ack_vld;
    logic [PTR_W-1:0]     grant_idx, ack_idx;
    logic [SCORE_W-1:0]   ack_score;

    // First requester at or after ptr (wrapping); MSB of the result flags a hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        int k;
        res = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NUM_CORES;
            if (req[k]) res = {1'b1, PTR_W'(k)};
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return PTR_W'((int'(p) + 1) % NUM_CORES);
    endfunction

    assign grant_req  = (state_q == S_RUN && !stop_i) ? (core_ready_i & ~outst_q) : '0;
    assign ack_req    = (state_q != S_IDLE) ? (core_done_i & outst_q) : '0;
    assign grant_pick = rr_pick(grant_req, iss_ptr_q);
    assign ack_pick   = rr_pick(ack_req, col_ptr_q);
    assign grant_vld  = grant_pick[PTR_W];
    assign grant_idx  = grant_pick[PTR_W-1:0];
    assign ack_vld    = ack_pick[PTR_W];
    assign ack_idx    = ack_pick[PTR_W-1:0];
    assign ack_score  = core_score_i[int'(ack_idx)*SCORE_W +: SCORE_W];

    assign core_start_o   = grant_vld ? (NUM_CORES'(1) << grant_idx) : '0;
    assign core_nonce_o   = grant_vld ? next_nonce_q : '0;
    assign core_ack_o     = ack_vld ? (NUM_CORES'(1) << ack_idx) : '0;
    assign busy_o         = (state_q != S_IDLE);
    assign best_valid_o   = best_valid_q;
    assign best_score_o   = best_score_q;
    assign best_nonce_o   = best_nonce_q;
    assign best_update_o  = best_update_q;
    assign issued_count_o = issued_q;

    always_comb begin
        state_d       = state_q;
        outst_d       = outst_q;
        iss_ptr_d     = iss_ptr_q;
        col_ptr_d     = col_ptr_q;
        next_nonce_d  = next_nonce_q;
        issued_d      = issued_q;
        best_valid_d  = best_valid_q;
        best_score_d  = best_score_q;
        best_nonce_d  = best_nonce_q;
        best_update_d = 1'b0;

        if (grant_vld) begin
            outst_d[grant_idx] = 1'b1;
            next_nonce_d       = next_nonce_q + 1'b1;
            issued_d           = issued_q + 1'b1;
            iss_ptr_d          = ptr_inc(grant_idx);
        end
        // Strict less-than keeps the earlier result on a tie.
        if (ack_vld) begin
            outst_d[ack_idx] = 1'b0;
            col_ptr_d        = ptr_inc(ack_idx);
            if (!best_valid_q || ack_score < best_score_q) begin
                best_valid_d  = 1'b1;
                best_score_d  = ack_score;
                best_nonce_d  = nonce_tbl_q[ack_idx];
                best_update_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_RUN;
                    next_nonce_d = nonce_base_i;
                    issued_d     = '0;
                    best_valid_d = 1'b0;
                    best_score_d = '1;
                end
            end
            S_RUN: begin
                if (stop_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (outst_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            outst_q       <= '0;
            iss_ptr_q     <= '0;
            col_ptr_q     <= '0;
            next_nonce_q  <= '0;
            issued_q      <= '0;
            best_valid_q  <= 1'b0;
            best_score_q  <= '1;
            best_nonce_q  <= '0;
            best_update_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            outst_q       <= outst_d;
            iss_ptr_q     <= iss_ptr_d;
            col_ptr_q     <= col_ptr_d;
            next_nonce_q  <= next_nonce_d;
            issued_q      <= issued_d;
            best_valid_q  <= best_valid_d;
            best_score_q  <= best_score_d;
            best_nonce_q  <= best_nonce_d;
            best_update_q <= best_update_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant_vld) nonce_tbl_q[grant_idx] <= next_nonce_q;
    end
endmodule

// File: tb/tb_hash_core_scheduler.sv
// Randomized and directed bench for hash_core_scheduler against a cycle-level
// behavioural model of the dispatch/collect/best-score rules.
module tb_hash_core_scheduler;
    localparam int NC = 4;
    localparam int NW = 32;
    localparam int SW = 11;

    logic              clk;
    logic              rst_i, start_i, stop_i;
    logic [NW-1:0]     nonce_base_i;
    logic [NC-1:0]     core_ready_i, core_done_i;
    logic [NC*SW-1:0]  core_score_i;
    logic [NC-1:0]     core_start_o, core_ack_o;
    logic [NW-1:0]     core_nonce_o, best_nonce_o, issued_count_o;
    logic              busy_o, best_valid_o, best_update_o;
    logic [SW-1:0]     best_score_o;

    hash_core_scheduler #(.NUM_CORES(NC), .NONCE_W(NW), .SCORE_W(SW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .nonce_base_i(nonce_base_i), .core_ready_i(core_ready_i),
        .core_start_o(core_start_o), .core_nonce_o(core_nonce_o),
        .core_done_i(core_done_i), .core_score_i(core_score_i),
        .core_ack_o(core_ack_o), .busy_o(busy_o), .best_valid_o(best_valid_o),
        .best_score_o(best_score_o), .best_nonce_o(best_nonce_o),
        .best_update_o(best_update_o), .issued_count_o(issued_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0=idle 1=running 2=draining
    int            m_mode;
    bit            m_out [NC];
    int            m_ip, m_cp;
    logic [NW-1:0] m_next, m_iss, m_bn;
    logic [NW-1:0] m_tbl [NC];
    bit            m_bv, m_upd, known;
    logic [SW-1:0] m_bs;

    // Values seen in the most recent step, for the literal checks
    logic [NC-1:0] cap_start, cap_ack;
    logic [NW-1:0] cap_nonce, cap_iss, cap_bn;
    logic          cap_busy, cap_bv, cap_upd;
    logic [SW-1:0] cap_bs;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_scores(input int s0, input int s1, input int s2, input int s3);
        core_score_i = {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    endtask

    task automatic step();
        int g, a, any;
        logic [SW-1:0] s;
        @(negedge clk);
        g = -1;
        a = -1;
        if (m_mode == 1 && !stop_i)
            for (int off = 0; off < NC; off++)
                if (g < 0 && core_ready_i[(m_ip + off) % NC] && !m_out[(m_ip + off) % NC])
                    g = (m_ip + off) % NC;
        if (m_mode != 0)
            for (int off = 0; off < NC; off++)
                if (a < 0 && core_done_i[(m_cp + off) % NC] && m_out[(m_cp + off) % NC])
                    a = (m_cp + off) % NC;

        cap_start = core_start_o; cap_nonce = core_nonce_o; cap_ack = core_ack_o;
        cap_busy = busy_o; cap_bv = best_valid_o; cap_bs = best_score_o;
        cap_bn = best_nonce_o; cap_upd = best_update_o; cap_iss = issued_count_o;

        if (known) begin
            chk("core_start", core_start_o, (g >= 0) ? 64'(1 << g) : 64'd0);
            if (g >= 0) chk("core_nonce", core_nonce_o, m_next);
            chk("core_ack", core_ack_o, (a >= 0) ? 64'(1 << a) : 64'd0);
            chk("busy", busy_o, 64'(m_mode != 0));
            chk("best_valid", best_valid_o, 64'(m_bv));
            chk("best_score", best_score_o, m_bs);
            chk("best_nonce", best_nonce_o, m_bn);
            chk("best_update", best_update_o, 64'(m_upd));
            chk("issued_count", issued_count_o, m_iss);
        end

        if (rst_i) begin
            m_mode = 0; m_ip = 0; m_cp = 0; m_next = 0; m_iss = 0;
            m_bv = 0; m_bs = '1; m_bn = 0; m_upd = 0;
            foreach (m_out[i]) m_out[i] = 0;
            known = 1;
        end else begin
            m_upd = 0;
            if (a >= 0) begin
                s = core_score_i[a*SW +: SW];
                m_out[a] = 0;
                m_cp = (a + 1) % NC;
                if (!m_bv || s < m_bs) begin
                    m_bv = 1; m_bs = s; m_bn = m_tbl[a]; m_upd = 1;
                end
            end
            if (g >= 0) begin
                m_tbl[g] = m_next;
                m_out[g] = 1;
                m_next = m_next + 1;
                m_iss = m_iss + 1;
                m_ip = (g + 1) % NC;
            end
            any = 0;
            foreach (m_out[i]) any += int'(m_out[i]);
            if (m_mode == 0 && start_i) begin
                m_mode = 1; m_next = nonce_base_i; m_iss = 0; m_bv = 0; m_bs = '1;
            end else if (m_mode == 1 && stop_i) begin
                m_mode = 2;
            end else if (m_mode == 2 && any == 0) begin
                m_mode = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NC-1:0] acks [4];
        int pulses;
        known = 0;
        m_mode = 0;
        rst_i = 1; start_i = 0; stop_i = 0; nonce_base_i = '0;
        core_ready_i = '0; core_done_i = '0; core_score_i = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles
        step(); step();
        rst_i = 0;
        step();
        chk("rst_busy", cap_busy, 0);
        chk("rst_start", cap_start, 0);
        chk("rst_ack", cap_ack, 0);
        chk("rst_best_valid", cap_bv, 0);
        chk("rst_best_score", cap_bs, 11'h7FF);

        // Four ready cores get sequential nonces in order
        core_ready_i = 4'hF; nonce_base_i = 32'h100; start_i = 1;
        step();
        start_i = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("disp_onehot", cap_start, 64'(1 << i));
            chk("disp_nonce", cap_nonce, 64'(32'h100 + i));
        end
        step();
        chk("disp_none", cap_start, 0);

        // All done together: collected in order, ties keep the earlier nonce
        core_ready_i = '0; core_done_i = 4'hF; set_scores(400, 390, 390, 500);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 4) acks[i] = cap_ack;
            pulses += int'(cap_upd);
        end
        for (int i = 0; i < 4; i++) chk("collect_order", acks[i], 64'(1 << i));
        chk("update_pulses", pulses, 2);
        chk("best_score_390", cap_bs, 390);
        chk("best_nonce_101", cap_bn, 32'h101);
        core_done_i = '0;
        stop_i = 1; step();
        stop_i = 0; step();
        step();
        chk("idle_after_stop", cap_busy, 0);

        // Nonce wrap with two ready cores (1 and 3)
        core_ready_i = 4'b1010; nonce_base_i = 32'hFFFF_FFFF; start_i = 1;
        step();
        start_i = 0;
        step();
        chk("wrap_core1", cap_start, 4'b0010);
        chk("wrap_nonce0", cap_nonce, 32'hFFFF_FFFF);
        step();
        chk("wrap_core3", cap_start, 4'b1000);
        chk("wrap_nonce1", cap_nonce, 32'h0);
        step();
        chk("wrap_issued", cap_iss, 2);

        // Stop with cores 1 and 3 outstanding, then drain
        core_ready_i = 4'hF; stop_i = 1;
        step();
        chk("stop_no_start", cap_start, 0);
        stop_i = 0;
        step();
        chk("drain_no_start", cap_start, 0);
        chk("drain_busy", cap_busy, 1);
        core_done_i = 4'b0010; set_scores(0, 7, 0, 3);
        step();
        chk("drain_ack1", cap_ack, 4'b0010);
        core_done_i = 4'b1010;
        step();
        chk("drain_ack3", cap_ack, 4'b1000);
        chk("drain_busy_last", cap_busy, 1);
        core_done_i = '0;
        step();
        chk("drain_idle", cap_busy, 0);
        chk("drain_best", cap_bs, 3);

        // Reset mid-run with three in flight and done held
        core_ready_i = 4'b0111; nonce_base_i = 32'h55; start_i = 1;
        step();
        start_i = 0;
        step(); step(); step();
        core_ready_i = '0; core_done_i = 4'b0111; rst_i = 1;
        step();
        rst_i = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_run_ack", cap_ack, 0);
            chk("rst_run_busy", cap_busy, 0);
        end
        core_done_i = '0;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_i        = ($urandom_range(0, 399) == 0);
            start_i      = ($urandom_range(0, 7) == 0);
            stop_i       = ($urandom_range(0, 23) == 0);
            nonce_base_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                                        : $urandom;
            core_ready_i = NC'($urandom);
            core_done_i  = NC'($urandom & $urandom);
            set_scores($urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 1024));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
